// File: rtl/hydra_pkg.sv
// Shared sizes, header layout and enums for the hydra 4-port store-and-forward switch.
package hydra_pkg;
  localparam int NUM_PORTS = 4;
  localparam int DATA_W    = 16;
  localparam int BUF_DEPTH = 512;
  localparam int PKT_SLOTS = 8;
  localparam int ADDR_W    = 9;
  localparam int PTR_W     = 10;
  localparam int LEN_W     = 10;
  localparam int CNT_W     = 4;
  localparam int SLOT_W    = 3;
  localparam int AGE_W     = 4;

  localparam logic [PTR_W-1:0] DEPTH_WORDS = PTR_W'(BUF_DEPTH);
  // A new packet is only accepted if a maximum-size frame (header + 255 + 2 spare) still fits.
  localparam logic [PTR_W-1:0] MIN_FREE    = PTR_W'(258);
  localparam logic [CNT_W-1:0] SLOTS_FULL  = CNT_W'(PKT_SLOTS);

  typedef struct packed {
    logic [3:0] rsvd;
    logic [7:0] len;
    logic [1:0] prio;
    logic [1:0] dest;
  } hdr_t;

  typedef enum logic [1:0] {
    MODE_INDEX    = 2'd0,
    MODE_PRIO     = 2'd1,
    MODE_AGING    = 2'd2,
    MODE_PRIO_ALT = 2'd3
  } match_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOP  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOP  = 2'd3
  } rd_state_e;
endpackage

// File: rtl/hydra_in_buf.sv
// Per-input packet buffer: word RAM, committed-packet FIFO (header + length), drop and pause logic.
module hydra_in_buf
  import hydra_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_sop,
  input  logic              wr_eop,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              pop,
  output logic              pause,
  output logic              head_vld,
  output logic [DATA_W-1:0] head_hdr,
  output logic [LEN_W-1:0]  head_len,
  output logic [DATA_W-1:0] rd_q
);
  logic [DATA_W-1:0] ram      [BUF_DEPTH];
  logic [DATA_W-1:0] hdr_fifo [PKT_SLOTS];
  logic [LEN_W-1:0]  len_fifo [PKT_SLOTS];

  logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_base, rd_ptr;
  logic [SLOT_W-1:0] head_idx, tail_idx;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              in_pkt, first_word;
  logic [DATA_W-1:0] cur_hdr;

  logic [PTR_W-1:0]  used, free_w, pkt_len;
  logic              slots_full, ram_we, push;

  assign used       = wr_ptr - rd_base;
  assign free_w     = DEPTH_WORDS - used;
  assign pkt_len    = wr_ptr - commit_ptr;
  assign slots_full = (pkt_cnt == SLOTS_FULL);
  // Priority among strobes: sop restarts, then vld, then eop.
  assign ram_we     = !wr_sop && wr_vld && in_pkt && (used != DEPTH_WORDS);
  assign push       = !wr_sop && !wr_vld && wr_eop && in_pkt && (pkt_len != '0);

  assign head_vld = (pkt_cnt != '0);
  assign head_hdr = hdr_fifo[head_idx];
  assign head_len = len_fifo[head_idx];

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_ptr[ADDR_W-1:0]] <= wr_data;
    rd_q <= ram[rd_ptr[ADDR_W-1:0]];
    if (push) begin
      hdr_fifo[tail_idx] <= cur_hdr;
      len_fifo[tail_idx] <= pkt_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_base    <= '0;
      rd_ptr     <= '0;
      head_idx   <= '0;
      tail_idx   <= '0;
      pkt_cnt    <= '0;
      in_pkt     <= 1'b0;
      first_word <= 1'b0;
      cur_hdr    <= '0;
      pause      <= 1'b0;
    end else begin
      pause <= (free_w < MIN_FREE) || slots_full;
      if (wr_sop) begin
        in_pkt     <= (free_w >= MIN_FREE) && !slots_full;
        first_word <= 1'b1;
        wr_ptr     <= commit_ptr;
      end else if (wr_vld && in_pkt) begin
        if (ram_we) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (first_word) begin
            cur_hdr    <= wr_data;
            first_word <= 1'b0;
          end
        end else begin
          // Buffer overflow mid-packet: discard everything written so far.
          in_pkt <= 1'b0;
          wr_ptr <= commit_ptr;
        end
      end else if (wr_eop && in_pkt) begin
        in_pkt <= 1'b0;
        if (push) begin
          commit_ptr <= wr_ptr;
          tail_idx   <= tail_idx + SLOT_W'(1);
        end
      end
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop) begin
        rd_base  <= rd_base + head_len;
        head_idx <= head_idx + SLOT_W'(1);
      end
      pkt_cnt <= pkt_cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule

// File: rtl/hydra_top.sv
// hydra switch top: four input buffers, per-output arbiter (index / priority / aging) and read FSM.
// Handshake: ready[o] is a level sampled each cycle; it is honoured only when output o is idle
// and some candidate exists, and is never remembered.
module hydra_top
  import hydra_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              wr_sop,
  input  logic [NUM_PORTS-1:0]              wr_eop,
  input  logic [NUM_PORTS-1:0]              wr_vld,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wr_data,
  output logic [NUM_PORTS-1:0]              pause,
  input  logic [NUM_PORTS-1:0]              ready,
  output logic [NUM_PORTS-1:0]              rd_sop,
  output logic [NUM_PORTS-1:0]              rd_eop,
  output logic [NUM_PORTS-1:0]              rd_vld,
  output logic [NUM_PORTS-1:0][DATA_W-1:0]  rd_data,
  input  logic [NUM_PORTS-1:0]              wrr_en,
  input  logic [3:0]                        match_threshold,
  input  logic [1:0]                        match_mode,
  output logic [2*NUM_PORTS-1:0]            dbg_state
);
  logic [NUM_PORTS-1:0]           head_vld, rd_en, pop, in_busy;
  logic [DATA_W-1:0]              head_hdr [NUM_PORTS];
  logic [LEN_W-1:0]               head_len [NUM_PORTS];
  logic [DATA_W-1:0]              rd_q     [NUM_PORTS];
  logic [NUM_PORTS-1:0][1:0]      prio_v;
  logic [NUM_PORTS-1:0]           cand     [NUM_PORTS];
  logic [2:0]                     grant    [NUM_PORTS];

  rd_state_e                      state_r [NUM_PORTS], state_n [NUM_PORTS];
  logic [1:0]                     sel_r   [NUM_PORTS], sel_n   [NUM_PORTS];
  logic [1:0]                     rr_r    [NUM_PORTS], rr_n    [NUM_PORTS];
  logic [LEN_W-1:0]               len_r   [NUM_PORTS], len_n   [NUM_PORTS];
  logic [LEN_W-1:0]               cnt_r   [NUM_PORTS], cnt_n   [NUM_PORTS];
  logic [NUM_PORTS-1:0][AGE_W-1:0] age_r  [NUM_PORTS], age_n   [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_buf
    hydra_in_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_sop   (wr_sop[i]),
      .wr_eop   (wr_eop[i]),
      .wr_vld   (wr_vld[i]),
      .wr_data  (wr_data[i]),
      .rd_en    (rd_en[i]),
      .pop      (pop[i]),
      .pause    (pause[i]),
      .head_vld (head_vld[i]),
      .head_hdr (head_hdr[i]),
      .head_len (head_len[i]),
      .rd_q     (rd_q[i])
    );
    assign prio_v[i] = head_hdr[i][3:2];
  end

  // Returns {found, index}. Aged candidates override priority only in aging mode.
  function automatic logic [2:0] pick(input logic [NUM_PORTS-1:0] cnd,
                                      input logic [NUM_PORTS-1:0][1:0] prio,
                                      input logic [NUM_PORTS-1:0][AGE_W-1:0] ages,
                                      input logic [1:0] mode, input logic [3:0] thr,
                                      input logic wrr, input logic [1:0] ptr);
    logic [NUM_PORTS-1:0] aged, elig;
    logic [1:0] best, idx;
    logic [2:0] res;
    aged = '0;
    best = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (cnd[i] && ages[i] >= thr) aged[i] = 1'b1;
      if (cnd[i] && prio[i] > best) best = prio[i];
    end
    elig = cnd;
    if (mode != MODE_INDEX)
      for (int i = 0; i < NUM_PORTS; i++) if (prio[i] != best) elig[i] = 1'b0;
    if (mode == MODE_AGING && aged != '0) elig = aged;
    res = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = wrr ? ptr + 2'(k) : 2'(k);
      if (!res[2] && elig[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    in_busy = '0;
    for (int o = 0; o < NUM_PORTS; o++)
      if (state_r[o] != ST_IDLE) in_busy[sel_r[o]] = 1'b1;
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++)
        cand[o][i] = head_vld[i] && (head_hdr[i][1:0] == 2'(o)) && !in_busy[i];
      grant[o] = pick(cand[o], prio_v, age_r[o], match_mode, match_threshold,
                      wrr_en[o], rr_r[o]);
    end
  end

  always_comb begin
    rd_en = '0;
    pop   = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      state_n[o] = state_r[o];
      sel_n[o]   = sel_r[o];
      rr_n[o]    = rr_r[o];
      len_n[o]   = len_r[o];
      cnt_n[o]   = cnt_r[o];
      age_n[o]   = age_r[o];
      case (state_r[o])
        ST_IDLE: if (ready[o] && grant[o][2]) begin
          state_n[o] = ST_SOP;
          sel_n[o]   = grant[o][1:0];
          rr_n[o]    = grant[o][1:0] + 2'd1;
          len_n[o]   = head_len[grant[o][1:0]];
          cnt_n[o]   = '0;
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (2'(i) == grant[o][1:0]) age_n[o][i] = '0;
            else if (cand[o][i] && age_r[o][i] != '1) age_n[o][i] = age_r[o][i] + AGE_W'(1);
          end
        end
        ST_SOP: begin
          rd_en[sel_r[o]] = 1'b1;
          state_n[o]      = ST_DATA;
        end
        ST_DATA: begin
          // RAM read is registered, so the final word needs no further fetch.
          if (cnt_r[o] == len_r[o] - LEN_W'(1)) state_n[o] = ST_EOP;
          else rd_en[sel_r[o]] = 1'b1;
          cnt_n[o] = cnt_r[o] + LEN_W'(1);
        end
        ST_EOP: begin
          pop[sel_r[o]] = 1'b1;
          state_n[o]    = ST_IDLE;
        end
        default: state_n[o] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (rst_n) begin
        state_r[o] <= ST_IDLE;
        sel_r[o]   <= '0;
        rr_r[o]    <= '0;
        len_r[o]   <= '0;
        cnt_r[o]   <= '0;
        age_r[o]   <= '0;
      end else begin
        state_r[o] <= state_n[o];
        sel_r[o]   <= sel_n[o];
        rr_r[o]    <= rr_n[o];
        len_r[o]   <= len_n[o];
        cnt_r[o]   <= cnt_n[o];
        age_r[o]   <= age_n[o];
      end
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      rd_sop[o]          = (state_r[o] == ST_SOP);
      rd_vld[o]          = (state_r[o] == ST_DATA);
      rd_eop[o]          = (state_r[o] == ST_EOP);
      rd_data[o]         = (state_r[o] == ST_DATA) ? rd_q[sel_r[o]] : '0;
      dbg_state[o*2 +: 2] = state_r[o];
    end
  end
endmodule

// File: tb/tb_hydra_top.sv
// Directed bench for hydra_top: table of single-packet round trips plus arbitration,
// backpressure, parallel streaming and reset-mid-read sequences, checked cycle by cycle.
module tb_hydra_top;
  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        wr_sop, wr_eop, wr_vld, pause, ready;
  logic [3:0][15:0]  wr_data, rd_data;
  logic [3:0]        rd_sop, rd_eop, rd_vld, wrr_en, match_threshold;
  logic [1:0]        match_mode;
  logic [7:0]        dbg_state;

  int checks = 0;
  int failures = 0;
  int exp_n [4];
  logic [15:0] exp_hdr [4];
  int exp_tag [4];

  typedef struct {
    int          in_port;
    logic [15:0] hdr;
    int          nwords;
    int          tag;
    int          exp_out;
    int          exp_eop_cyc;
  } vec_t;
  vec_t vecs [6];

  hydra_top dut (
    .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
    .wr_data(wr_data), .pause(pause), .ready(ready), .rd_sop(rd_sop), .rd_eop(rd_eop),
    .rd_vld(rd_vld), .rd_data(rd_data), .wrr_en(wrr_en), .match_threshold(match_threshold),
    .match_mode(match_mode), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    wr_sop = '0; wr_eop = '0; wr_vld = '0; wr_data = '0; ready = '0;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  function automatic logic [15:0] wordv(input logic [15:0] hdr, input int tag, input int k);
    logic [7:0] t8, k8;
    t8 = tag[7:0];
    k8 = k[7:0];
    return (k == 0) ? hdr : {t8, k8};
  endfunction

  task automatic write_pkt(input int p, input logic [15:0] hdr, input int n, input int tag);
    wr_sop[p] = 1'b1;
    tick();
    wr_sop[p] = 1'b0;
    for (int k = 0; k < n; k++) begin
      wr_vld[p]  = 1'b1;
      wr_data[p] = wordv(hdr, tag, k);
      tick();
    end
    wr_vld[p]  = 1'b0;
    wr_data[p] = '0;
    wr_eop[p]  = 1'b1;
    tick();
    wr_eop[p] = 1'b0;
  endtask

  task automatic clear_exp();
    for (int o = 0; o < 4; o++) begin
      exp_n[o] = 0; exp_hdr[o] = '0; exp_tag[o] = 0;
    end
  endtask

  task automatic set_exp(input int o, input logic [15:0] hdr, input int n, input int tag);
    exp_n[o] = n; exp_hdr[o] = hdr; exp_tag[o] = tag;
  endtask

  // Pulse ready for one sampling edge, then compare every output on every following cycle.
  task automatic read_check(input logic [3:0] rmask, input int ncyc, input string name);
    logic es, ev, ee;
    logic [15:0] ed;
    ready = rmask;
    tick();
    ready = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      for (int o = 0; o < 4; o++) begin
        es = 1'b0; ev = 1'b0; ee = 1'b0; ed = '0;
        if (exp_n[o] > 0) begin
          es = (c == 1);
          ev = (c >= 2) && (c <= exp_n[o] + 1);
          ee = (c == exp_n[o] + 2);
          if (ev) ed = wordv(exp_hdr[o], exp_tag[o], c - 2);
        end
        check($sformatf("%s_out%0d_c%0d", name, o, c),
              {45'd0, rd_sop[o], rd_vld[o], rd_eop[o], rd_data[o]},
              {45'd0, es, ev, ee, ed});
      end
    end
    @(posedge clk);
    #1;
    clear_exp();
  endtask

  initial begin
    vecs[0] = '{0, 16'h0013, 1,  20, 3, 3};
    vecs[1] = '{1, 16'h0040, 4,  21, 0, 6};
    vecs[2] = '{2, 16'h0029, 3,  22, 1, 5};
    vecs[3] = '{3, 16'hA0FE, 2,  23, 2, 4};
    vecs[4] = '{2, 16'h0002, 7,  24, 2, 9};
    vecs[5] = '{0, 16'h0001, 16, 25, 1, 18};

    wrr_en = '0; match_mode = 2'd0; match_threshold = 4'd0;
    clear_exp();

    // Reset state
    do_reset();
    check("reset_ctrl", {52'd0, pause, rd_sop, rd_vld}, 64'd0);
    check("reset_eop_state", {52'd0, rd_eop, dbg_state}, 64'd0);
    check("reset_data", rd_data, 64'd0);

    // Table of single-packet round trips
    for (int v = 0; v < 6; v++) begin
      write_pkt(vecs[v].in_port, vecs[v].hdr, vecs[v].nwords, vecs[v].tag);
      set_exp(vecs[v].exp_out, vecs[v].hdr, vecs[v].exp_eop_cyc - 2, vecs[v].tag);
      read_check(4'(1 << vecs[v].exp_out), vecs[v].exp_eop_cyc + 1, $sformatf("vec%0d", v));
    end

    // Two equal packets to output 3, round robin, then nothing left
    do_reset();
    wrr_en = 4'hF; match_mode = 2'd2; match_threshold = 4'd15;
    write_pkt(0, 16'h01F7, 32, 1);
    write_pkt(1, 16'h01F7, 32, 2);
    set_exp(3, 16'h01F7, 32, 1);
    read_check(4'b1000, 35, "rr_first");
    set_exp(3, 16'h01F7, 32, 2);
    read_check(4'b1000, 35, "rr_second");
    read_check(4'b1000, 5, "rr_empty");

    // Strict priority
    do_reset();
    wrr_en = 4'h0; match_mode = 2'd1;
    write_pkt(0, 16'h0032, 3, 3);
    write_pkt(2, 16'h003E, 3, 4);
    set_exp(2, 16'h003E, 3, 4);
    read_check(4'b0100, 6, "prio_high");
    set_exp(2, 16'h0032, 3, 3);
    read_check(4'b0100, 6, "prio_low");

    // Aging: low-priority head wins on the third grant
    do_reset();
    wrr_en = 4'h0; match_mode = 2'd2; match_threshold = 4'd2;
    write_pkt(0, 16'h0011, 2, 5);
    write_pkt(1, 16'h001D, 2, 6);
    write_pkt(1, 16'h001D, 2, 7);
    write_pkt(1, 16'h001D, 2, 8);
    set_exp(1, 16'h001D, 2, 6);
    read_check(4'b0010, 5, "age_g1");
    set_exp(1, 16'h001D, 2, 7);
    read_check(4'b0010, 5, "age_g2");
    set_exp(1, 16'h0011, 2, 5);
    read_check(4'b0010, 5, "age_g3");
    set_exp(1, 16'h001D, 2, 8);
    read_check(4'b0010, 5, "age_g4");

    // Backpressure: third packet dropped while pause is up
    do_reset();
    match_mode = 2'd0;
    write_pkt(0, 16'h0000, 200, 9);
    tick();
    check("bp_pause_one_pkt", {60'd0, pause}, 64'd0);
    write_pkt(0, 16'h0000, 200, 10);
    tick();
    check("bp_pause_full", {60'd0, pause}, 64'h1);
    write_pkt(0, 16'h0000, 5, 11);
    set_exp(0, 16'h0000, 200, 9);
    read_check(4'b0001, 203, "bp_pkt1");
    set_exp(0, 16'h0000, 200, 10);
    read_check(4'b0001, 203, "bp_pkt2");
    read_check(4'b0001, 4, "bp_dropped");
    tick();
    check("bp_pause_clear", {60'd0, pause}, 64'd0);

    // Parallel streaming on all four outputs
    do_reset();
    write_pkt(3, 16'h0050, 5, 12);
    write_pkt(2, 16'h0041, 4, 13);
    write_pkt(1, 16'h0032, 3, 14);
    write_pkt(0, 16'h0063, 6, 15);
    set_exp(0, 16'h0050, 5, 12);
    set_exp(1, 16'h0041, 4, 13);
    set_exp(2, 16'h0032, 3, 14);
    set_exp(3, 16'h0063, 6, 15);
    read_check(4'hF, 9, "par");

    // Reset in the middle of a read
    do_reset();
    write_pkt(0, 16'h0013, 10, 16);
    ready = 4'b1000;
    tick();
    ready = '0;
    tick();
    tick();
    check("mid_streaming", {60'd0, rd_vld}, 64'h8);
    check("mid_word", {48'd0, rd_data[3]}, {48'd0, wordv(16'h0013, 16, 1)});
    rst_n = 1'b1;
    tick();
    check("mid_rst_ctrl", {52'd0, rd_sop, rd_vld, rd_eop}, 64'd0);
    check("mid_rst_data", rd_data, 64'd0);
    check("mid_rst_state", {56'd0, dbg_state}, 64'd0);
    rst_n = 1'b0;
    tick();
    read_check(4'b1000, 4, "mid_rst_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
